y86_seq_controller: RTL and testbench

//  Multi-cycle stage sequencer and program loader for the Y-86 SEQ core.

---
 rtl/y86_seq_controller.sv | 173 +++++++++++++++++
 tb/tb_y86_seq_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Stage sequencer and program loader for the Y-86 SEQ core: loads imem, steps F/D/E/M/W, owns STAT.
// Optional single-step mode (step input, PAUSE state) is enabled by defining Y86_SEQ_SINGLE_STEP_EN.
module y86_seq_controller #(
  parameter int IMEM_BYTES = 80,
  parameter int ADDR_W     = 7,
  parameter int CNT_W      = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [7:0]        o_imem_wdata,
  output logic              o_load_ovf,
  input  logic              i_start,
  input  logic [3:0]        i_icode,
  input  logic              i_instr_valid,
  input  logic [63:0]       i_pc,
  input  logic              i_dmem_err,
`ifdef Y86_SEQ_SINGLE_STEP_EN
  input  logic              i_step,
`endif
  output logic [4:0]        o_stage_en,
  output logic              o_pc_we,
  output logic [2:0]        o_stat,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_instr_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(IMEM_BYTES);
  localparam logic [63:0]       PC_LIM   = 64'(IMEM_BYTES);
  localparam logic [2:0] ST_AOK = 3'd1, ST_HLT = 3'd2, ST_ADR = 3'd3, ST_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT, S_ERROR
`ifdef Y86_SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic               r_load_ovf;
  logic [2:0]         r_stat, w_stat_nxt;
  logic [CNT_W-1:0]   r_cycle_cnt, r_instr_cnt;
  logic [4:0]         r_stage_en, w_stage_nxt;
  logic               r_pc_we, w_pc_we_nxt;
  logic               w_accept, w_drop, w_retire, w_busy;

  always_comb begin
    w_next      = r_state;
    w_stat_nxt  = r_stat;
    w_pc_we_nxt = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_load_valid && (r_imem_addr < ADDR_LIM);
        w_drop   = i_load_valid && (r_imem_addr >= ADDR_LIM);
        if (i_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!i_instr_valid || (i_pc >= PC_LIM)) begin
          w_next     = S_ERROR;
          w_stat_nxt = ST_ADR;
        end else if (i_icode > 4'hB) begin
          w_next     = S_ERROR;
          w_stat_nxt = ST_INS;
        end else begin
          w_next = S_DECODE;
        end
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_MEMORY;
      S_MEMORY: begin
        if (i_dmem_err) begin
          w_next     = S_ERROR;
          w_stat_nxt = ST_ADR;
        end else begin
          w_next      = S_WRITEBACK;
          // pc_we is registered, so the halt test is made one cycle early
          w_pc_we_nxt = (i_icode != 4'h0);
        end
      end
      S_WRITEBACK: begin
        w_retire = 1'b1;
        if (i_icode == 4'h0) begin
          w_next     = S_HALT;
          w_stat_nxt = ST_HLT;
        end else begin
`ifdef Y86_SEQ_SINGLE_STEP_EN
          w_next = S_PAUSE;
`else
          w_next = S_FETCH;
`endif
        end
      end
`ifdef Y86_SEQ_SINGLE_STEP_EN
      S_PAUSE: if (i_step) w_next = S_FETCH;
`endif
      S_HALT, S_ERROR: w_next = r_state;
      default: w_next = S_IDLE;
    endcase
    if (i_clear) begin
      w_next      = S_IDLE;
      w_stat_nxt  = ST_AOK;
      w_pc_we_nxt = 1'b0;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      w_retire    = 1'b0;
    end
  end

  always_comb begin
    w_stage_nxt = 5'b00000;
    case (w_next)
      S_FETCH:     w_stage_nxt = 5'b10000;
      S_DECODE:    w_stage_nxt = 5'b01000;
      S_EXECUTE:   w_stage_nxt = 5'b00100;
      S_MEMORY:    w_stage_nxt = 5'b00010;
      S_WRITEBACK: w_stage_nxt = 5'b00001;
      default:     w_stage_nxt = 5'b00000;
    endcase
  end

  assign w_busy = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXECUTE) ||
                  (r_state == S_MEMORY) || (r_state == S_WRITEBACK);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_imem_addr <= '0;
      r_load_ovf  <= 1'b0;
      r_stat      <= ST_AOK;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
      r_stage_en  <= '0;
      r_pc_we     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_stage_en <= w_stage_nxt;
      r_pc_we    <= w_pc_we_nxt;
      r_stat     <= w_stat_nxt;
      if (i_clear) begin
        r_imem_addr <= '0;
        r_load_ovf  <= 1'b0;
        r_cycle_cnt <= '0;
        r_instr_cnt <= '0;
      end else begin
        if (w_accept) r_imem_addr <= r_imem_addr + 1'b1;
        if (w_drop)   r_load_ovf  <= 1'b1;
        if (w_busy && (r_cycle_cnt != '1))   r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (w_retire && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  assign o_imem_we    = w_accept;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = i_load_byte;
  assign o_load_ovf   = r_load_ovf;
  assign o_stage_en   = r_stage_en;
  assign o_pc_we      = r_pc_we;
  assign o_stat       = r_stat;
  assign o_busy       = w_busy;
  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: stimulus queues expected stage/write/status values,
// a negedge monitor pops and compares them against the DUT.
module tb_y86_seq_controller;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, load_valid = 1'b0, start = 1'b0;
  logic [7:0]  load_byte = '0;
  logic [3:0]  icode = '0;
  logic        instr_valid = 1'b1, dmem_err = 1'b0, step = 1'b0;
  logic [63:0] pc = '0;
  logic        imem_we, load_ovf, pc_we, busy;
  logic [6:0]  imem_addr;
  logic [7:0]  imem_wdata;
  logic [4:0]  stage_en;
  logic [2:0]  stat;
  logic [31:0] cycle_cnt, instr_cnt;

  y86_seq_controller dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear),
    .i_load_valid(load_valid), .i_load_byte(load_byte),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_load_ovf(load_ovf),
    .i_start(start), .i_icode(icode), .i_instr_valid(instr_valid), .i_pc(pc), .i_dmem_err(dmem_err),
`ifdef Y86_SEQ_SINGLE_STEP_EN
    .i_step(step),
`endif
    .o_stage_en(stage_en), .o_pc_we(pc_we), .o_stat(stat), .o_busy(busy),
    .o_cycle_cnt(cycle_cnt), .o_instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int { C_STAT, C_ADDR, C_OVF, C_CYC, C_INS, C_STG, C_BUSY, C_PCWE,
                     C_WE, C_PCWE_CNT, C_SQ, C_WQ } sel_t;
  typedef struct { sel_t sel; logic [63:0] exp; string name; } chk_t;

  chk_t        cq[$];
  logic [5:0]  sq[$];   // {stage_en, pc_we}
  logic [14:0] wq[$];   // {addr, data}
  int          n_tests = 0, n_fail = 0, pcwe_cnt = 0;
  chk_t        c;
  logic [63:0] act;
  logic [5:0]  se;
  logic [14:0] we;

  function automatic logic [63:0] sel_val(sel_t s);
    case (s)
      C_STAT:     return 64'(stat);
      C_ADDR:     return 64'(imem_addr);
      C_OVF:      return 64'(load_ovf);
      C_CYC:      return 64'(cycle_cnt);
      C_INS:      return 64'(instr_cnt);
      C_STG:      return 64'(stage_en);
      C_BUSY:     return 64'(busy);
      C_PCWE:     return 64'(pc_we);
      C_WE:       return 64'(imem_we);
      C_PCWE_CNT: return 64'(pcwe_cnt);
      C_SQ:       return 64'(sq.size());
      C_WQ:       return 64'(wq.size());
      default:    return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (cq.size() > 0) begin
      c = cq.pop_front();
      act = sel_val(c.sel);
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
      end
    end
    if (rst_n && (stage_en != 5'b0 || pc_we)) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL stage_unexpected: got stage_en=%b pc_we=%b expected none", stage_en, pc_we);
      end else begin
        se = sq.pop_front();
        if ({stage_en, pc_we} !== se) begin
          n_fail++;
          $display("FAIL stage_seq: got %b/%b expected %b/%b", stage_en, pc_we, se[5:1], se[0]);
        end
      end
    end
    if (rst_n && imem_we) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL imem_unexpected: got addr=%0d data=%0h expected no write", imem_addr, imem_wdata);
      end else begin
        we = wq.pop_front();
        if ({imem_addr, imem_wdata} !== we) begin
          n_fail++;
          $display("FAIL imem_write: got %0d/%0h expected %0d/%0h", imem_addr, imem_wdata, we[14:8], we[7:0]);
        end
      end
    end
    if (pc_we) pcwe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input sel_t s, input logic [63:0] e, input string nm);
    cq.push_back('{s, e, nm});
  endtask

  // push the first n stages of one instruction; W carries pc_we for non-halt
  task automatic push_instr(input logic [3:0] ic, input int n);
    logic [4:0] oh;
    for (int k = 0; k < n; k++) begin
      oh = 5'b10000 >> k;
      sq.push_back({oh, (k == 4) && (ic != 4'h0)});
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  int base;

  initial begin
    // reset state
    chk(C_STAT, 1, "rst_stat"); chk(C_ADDR, 0, "rst_addr"); chk(C_OVF, 0, "rst_ovf");
    chk(C_CYC, 0, "rst_cyc");   chk(C_INS, 0, "rst_ins");   chk(C_STG, 0, "rst_stage");
    chk(C_PCWE, 0, "rst_pcwe"); chk(C_BUSY, 0, "rst_busy"); chk(C_WE, 0, "rst_we");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: load 10 bytes, one instruction, then icode C at the next fetch
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_byte = 8'(8'h30 + i);
      wq.push_back({7'(i), 8'(8'h30 + i)});
      tick(1);
    end
    load_valid = 1'b0;
    chk(C_ADDR, 10, "t1_addr"); chk(C_OVF, 0, "t1_ovf");
    base = pcwe_cnt;
    icode = 4'h2; pc = 64'd0; start = 1'b1;
    push_instr(4'h2, 5); push_instr(4'hC, 1);
    tick(1);
    start = 1'b0;
    chk(C_BUSY, 1, "t1_busy");
    tick(5);
    icode = 4'hC;
    tick(1);
    chk(C_STAT, 4, "t3_stat_ins"); chk(C_INS, 1, "t3_ins"); chk(C_CYC, 6, "t3_cyc");
    chk(C_STG, 0, "t3_stage"); chk(C_BUSY, 0, "t3_busy");
    chk(C_PCWE_CNT, 64'(base + 1), "t1_pcwe_cnt");
    start = 1'b1;
    tick(2);
    start = 1'b0;
    chk(C_STAT, 4, "t3_start_ignored");
    tick(1);
    do_clear();
    chk(C_STAT, 1, "clr_stat"); chk(C_CYC, 0, "clr_cyc"); chk(C_INS, 0, "clr_ins");
    chk(C_ADDR, 0, "clr_addr");
    tick(1);

    // 2: nop,nop,halt with a byte loaded in the start cycle
    base = pcwe_cnt;
    load_valid = 1'b1; load_byte = 8'h10; wq.push_back({7'd0, 8'h10});
    icode = 4'h1; pc = 64'd4; start = 1'b1;
    push_instr(4'h1, 5); push_instr(4'h1, 5); push_instr(4'h0, 5);
    tick(1);
    load_valid = 1'b0; start = 1'b0;
    tick(5);
    tick(5);
    icode = 4'h0;
    tick(5);
    chk(C_STAT, 2, "t2_stat_hlt"); chk(C_INS, 3, "t2_ins"); chk(C_CYC, 15, "t2_cyc");
    chk(C_PCWE_CNT, 64'(base + 2), "t2_pcwe_cnt"); chk(C_BUSY, 0, "t2_busy");
    chk(C_ADDR, 1, "t2_addr");
    tick(1);
    do_clear();

    // 4: dmem_err during MEMORY
    base = pcwe_cnt;
    icode = 4'h3; pc = 64'd0; start = 1'b1;
    push_instr(4'h3, 4);
    tick(1);
    start = 1'b0;
    tick(3);
    dmem_err = 1'b1;
    tick(1);
    dmem_err = 1'b0;
    chk(C_STAT, 3, "t4_stat_adr"); chk(C_INS, 0, "t4_ins"); chk(C_CYC, 4, "t4_cyc");
    chk(C_PCWE_CNT, 64'(base), "t4_no_pcwe");
    tick(1);
    do_clear();

    // fetch address error outranks invalid icode; pc == IMEM_BYTES is out of range
    icode = 4'hC; pc = 64'd80; start = 1'b1;
    push_instr(4'hC, 1);
    tick(1);
    start = 1'b0;
    tick(1);
    chk(C_STAT, 3, "fetch_pc_adr"); chk(C_CYC, 1, "fetch_pc_cyc");
    tick(1);
    do_clear();
    icode = 4'h1; pc = 64'd79; instr_valid = 1'b0; start = 1'b1;
    push_instr(4'h1, 1);
    tick(1);
    start = 1'b0;
    tick(1);
    instr_valid = 1'b1;
    chk(C_STAT, 3, "fetch_invalid_adr");
    tick(1);
    do_clear();

    // 5: 81 bytes, overflow, clear dominates load_valid
    for (int i = 0; i < 81; i++) begin
      load_valid = 1'b1; load_byte = 8'(i ^ 8'h5A);
      if (i < 80) wq.push_back({7'(i), 8'(i ^ 8'h5A)});
      else        chk(C_WE, 0, "t5_we_dropped");
      tick(1);
    end
    load_valid = 1'b0;
    chk(C_OVF, 1, "t5_ovf"); chk(C_ADDR, 80, "t5_addr_nowrap");
    tick(1);
    clear = 1'b1; load_valid = 1'b1; load_byte = 8'hEE;
    chk(C_WE, 0, "t5_clear_blocks_we");
    tick(1);
    clear = 1'b0; load_valid = 1'b0;
    chk(C_ADDR, 0, "t5_clr_addr"); chk(C_OVF, 0, "t5_clr_ovf");
    tick(1);

    // 6: reset in the middle of EXECUTE
    icode = 4'h1; pc = 64'd0; start = 1'b1;
    push_instr(4'h1, 2);
    tick(1);
    start = 1'b0;
    tick(2);
    rst_n = 1'b0;
    chk(C_STG, 0, "t6_stage"); chk(C_PCWE, 0, "t6_pcwe"); chk(C_STAT, 1, "t6_stat");
    chk(C_CYC, 0, "t6_cyc");   chk(C_INS, 0, "t6_ins");   chk(C_BUSY, 0, "t6_busy");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    chk(C_SQ, 0, "stage_queue_drained"); chk(C_WQ, 0, "write_queue_drained");
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
